// File: rtl/fnv1a_reduce_seq.sv
// Sequential FNV-1a reduce engine: reads init word plus len array words, one per cycle, and writes the folded hash.
// Optional bounds check on cmd_len compiled in with `define FNV1A_REDUCE_SEQ_BOUNDS_CHECK_EN.
module fnv1a_reduce_seq #(
  parameter int ADDR_W  = 16,
  parameter int MAX_LEN = 48
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_arr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [ADDR_W-1:0] cmd_dest,
  input  logic [ADDR_W-1:0] cmd_init,
  input  logic              cmd_cond,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [31:0]       mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [31:0]       mem_wr_data,
  output logic              busy,
`ifdef FNV1A_REDUCE_SEQ_BOUNDS_CHECK_EN
  output logic              err,
`endif
  output logic              done
);

  localparam logic [31:0] FNV_PRIME = 32'h0100_0193;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, WRITE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] arr_q, len_q, dest_q, init_q;
  logic              cond_q, err_q;
  logic [31:0]       acc_q;
  logic              rd_pend_q, rd_first_q;
  logic              accept;
  logic              len_bad;
  logic [ADDR_W-1:0] cnt_lo;

  assign accept = cmd_valid && cmd_ready;
  assign cnt_lo = cnt_q[ADDR_W-1:0];

`ifdef FNV1A_REDUCE_SEQ_BOUNDS_CHECK_EN
  assign len_bad = 32'(cmd_len) > 32'(MAX_LEN);
  assign err     = err_q && (state_q == WRITE);
`else
  assign len_bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          // Skipped and out-of-bounds commands go straight to WRITE with no traffic
          state_d = (!cmd_cond || len_bad) ? WRITE : READ;
        end
      end
      READ: begin
        if (cnt_q == {1'b0, len_q}) begin
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN:   state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = (state_q == IDLE) && reset_n;
    busy        = (state_q != IDLE);
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    done        = 1'b0;
    if (state_q == READ) begin
      mem_rd_en   = 1'b1;
      mem_rd_addr = (cnt_q == '0) ? init_q : arr_q + cnt_lo - {{(ADDR_W-1){1'b0}}, 1'b1};
    end
    if (state_q == WRITE) begin
      done = 1'b1;
      if (cond_q && !err_q) begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = dest_q;
        mem_wr_data = acc_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      arr_q      <= '0;
      len_q      <= '0;
      dest_q     <= '0;
      init_q     <= '0;
      cond_q     <= 1'b0;
      err_q      <= 1'b0;
      acc_q      <= '0;
      rd_pend_q  <= 1'b0;
      rd_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_pend_q  <= mem_rd_en;
      rd_first_q <= mem_rd_en && (cnt_q == '0);
      if (accept) begin
        arr_q  <= cmd_arr;
        len_q  <= cmd_len;
        dest_q <= cmd_dest;
        init_q <= cmd_init;
        cond_q <= cmd_cond;
        err_q  <= cmd_cond && len_bad;
      end
      // Read data lands one cycle after its strobe; the init word seeds the hash
      if (rd_pend_q) begin
        acc_q <= rd_first_q ? mem_rd_data : (acc_q ^ mem_rd_data) * FNV_PRIME;
      end
    end
  end

endmodule

// File: doc/fnv1a_reduce_seq.md
# fnv1a_reduce_seq

Sequential controller that executes one FNV-1a reduce command per transaction against the shared u32 execution-environment memory. It reads the initial hash word and then `len` array words through a single read port, folds each word into a running hash, and writes the final hash to the destination word. It sits between the instruction decoder, which issues the command with the already-evaluated conditional flag, and the environment memory. It replaces the single-cycle combinational reduce with a one-word-per-cycle pipelined engine.

## Interface
- `ADDR_W`, 16: width of u32 word addresses and of the length field.
- `MAX_LEN`, 48: maximum legal `cmd_len`; only enforced when the bounds check is compiled in.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset_n` in 1: reset is synchronous and active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: engine idle and able to accept a command.
- `cmd_arr` in ADDR_W: first array word address.
- `cmd_len` in ADDR_W: number of array words to fold.
- `cmd_dest` in ADDR_W: address of the result word.
- `cmd_init` in ADDR_W: address of the initial hash word.
- `cmd_cond` in 1: evaluated conditional flag; 0 means skip.
- `mem_rd_en` out 1: read strobe.
- `mem_rd_addr` out ADDR_W: read address.
- `mem_rd_data` in 32: read data, valid exactly 1 cycle after `mem_rd_en`.
- `mem_wr_en` out 1: write strobe.
- `mem_wr_addr` out ADDR_W: write address.
- `mem_wr_data` out 32: write data.
- `busy` out 1: command in progress.
- `done` out 1: one-cycle pulse at command completion.
- `err` out 1: one-cycle pulse on a rejected command. Exists only when the bounds check is compiled in.

## Operation
- FSM states: IDLE, READ, DRAIN, WRITE.
- Command acceptance:
  - A command is accepted on an edge where `cmd_valid && cmd_ready`.
  - On acceptance, `arr`, `len`, `dest`, `init` and `cond` are latched.
  - `cmd_ready` is 1 only in IDLE.
- Skip path: if `cond==0`, the FSM goes IDLE→WRITE with `mem_wr_en` held at 0. `done` pulses and no memory access occurs.
- READ state:
  - Issues `len+1` reads in consecutive cycles: first `init`, then `arr+0` … `arr+len-1`.
  - Addresses wrap modulo 2^ADDR_W.
  - A read counter selects the address.
- DRAIN state: one cycle that waits for the last read's data.
- Accumulation, on each edge where the previous cycle issued a read:
  - The first returned word loads `acc`.
  - Each later word applies `acc = (acc ^ d) * 32'h01000193`, truncated to 32 bits.
- WRITE state:
  - One cycle with `mem_wr_en=1`, `mem_wr_addr=dest`, `mem_wr_data=acc`, `done=1`.
  - Next state is IDLE.
- `len==0`: one read (`init`), then a write of the initial value unchanged.
- Aliasing: all reads finish before the write, so `dest` may overlap `init` or the array range. A read and a write never occur in the same cycle.
- `busy` is 1 in READ, DRAIN and WRITE.

## Timing
- Reset values: `cmd_ready=0`, `mem_rd_en=0`, `mem_wr_en=0`, `busy=0`, `done=0`, `err=0`; addresses, write data and `acc` are 0.
  - `cmd_ready` rises in the first cycle after `reset_n` deasserts.
  - `cmd_valid` is ignored while `reset_n=0`.
- Cycle numbering: the accept edge is E0; cycle n follows edge En.
  - Reads occur in cycles 1..len+1.
  - DRAIN is cycle len+2.
  - WRITE and `done` occur in cycle len+3.
  - `cmd_ready` is back at 1 in cycle len+4.
- Latency from accept to write is len+3 cycles.
- Skip path: WRITE-state `done` in cycle 1, `cmd_ready` in cycle 2.
- Back-to-back commands: a command held valid is accepted on the edge that ends the first IDLE cycle. There is 1 idle cycle between commands.
- Reset mid-command: the FSM returns to IDLE at the next reset edge. No write is issued, `acc` is discarded, and every output takes its reset value.
- Command inputs are don't-care outside the accept edge.

## Configuration
- `FNV1A_REDUCE_SEQ_BOUNDS_CHECK_EN` defined:
  - A `cond==1` command with `cmd_len > MAX_LEN` goes to WRITE with `mem_wr_en=0`.
  - In that cycle `done=1` and `err=1`; no reads are issued.
  - Skipped commands (`cond==0`) are never flagged.
- Undefined: `err` does not exist and any `cmd_len` up to 2^ADDR_W−1 is processed in full.

## Test plan
- Basic hash:
  - Stimulus: mem[0x10]=0x811C9DC5, mem[0x20]=0x00000061; command init=0x10, arr=0x20, len=1, dest=0x30, cond=1.
  - Required response: reads at cycles 1–2, write 0xE40C292C to 0x30 in cycle 4, `done` pulse.
- Zero length:
  - Stimulus: mem[0x5]=0x12345678; command len=0, init=0x5, dest=0x6.
  - Required response: one read, 0x12345678 written to 0x6 in cycle 3.
- Skip:
  - Stimulus: command with cond=0.
  - Required response: no `mem_rd_en` or `mem_wr_en`, `done` in cycle 1, `cmd_ready` in cycle 2.
- Wrap and alias:
  - Stimulus: ADDR_W=16, arr=0xFFFE, len=4, dest=0xFFFF.
  - Required response: reads at 0xFFFE, 0xFFFF, 0x0000, 0x0001; result matches the reference model and is written to 0xFFFF after all reads.
- Reset mid-command:
  - Stimulus: len=8 command, `reset_n` low in cycle 4 for one edge.
  - Required response: no write; all outputs at reset values; the next command completes correctly.
- Bounds check (macro defined, MAX_LEN=48):
  - Stimulus: len=49, cond=1.
  - Required response: `err` and `done` in cycle 1, zero memory traffic.
  - Follow-up stimulus: len=48.
  - Required response: completes with the write in cycle 51.
